pwm_config_register_bank: RTL and testbench

Register-file responder on the PWM peripheral's configuration port. It accepts address/data/write-enable traffic from the configuration programmer and stores it in a shadow bank of `LOCATIONS` byte registers. At the end of each write burst it commits the whole shadow bank atomically to the active bank that drives the PWM modules. It also returns registered readback data on the bidirectional data pins, with output-enable control.

---
 rtl/pwm_config_register_bank.sv | 114 +++++++++++
 tb/tb_pwm_config_register_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_config_register_bank.sv
// PWM configuration register bank: shadow bank written by the programmer,
// committed atomically to the active bank at the end of each write burst.
//
// Ports:
//   i_clk       single clock, rising edge
//   i_reset_n   synchronous active-low reset
//   i_write_en  write strobe; its falling edge commits the shadow bank
//   i_address   register select (decoded only, never incremented)
//   i_data      write data
//   o_data      registered readback (write-first bypass on same edge)
//   o_data_oe   pin output enables: all 0 while writing, else all 1
//   o_config    active bank, register k at [k*DATA_SIZE +: DATA_SIZE]
//   o_update    one-cycle pulse after each commit
module pwm_config_register_bank #(
    parameter int ADDRESS_SIZE = 6,
    parameter int DATA_SIZE    = 8,
    parameter int LOCATIONS    = 49
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_write_en,
    input  logic [ADDRESS_SIZE-1:0]        i_address,
    input  logic [DATA_SIZE-1:0]           i_data,
    output logic [DATA_SIZE-1:0]           o_data,
    output logic [DATA_SIZE-1:0]           o_data_oe,
    output logic [LOCATIONS*DATA_SIZE-1:0] o_config,
    output logic                           o_update
);

    logic [DATA_SIZE-1:0] shadow_q [LOCATIONS];
    logic [DATA_SIZE-1:0] shadow_d [LOCATIONS];
    logic [DATA_SIZE-1:0] active_q [LOCATIONS];
    logic [DATA_SIZE-1:0] active_d [LOCATIONS];

    logic [DATA_SIZE-1:0] data_q;
    logic [DATA_SIZE-1:0] data_d;
    logic [DATA_SIZE-1:0] oe_q;
    logic [DATA_SIZE-1:0] oe_d;
    logic                 update_q;
    logic                 update_d;
    logic                 we_q;

    logic [DATA_SIZE-1:0] rd_data;
    logic                 addr_hit;
    logic                 commit;
    logic                 wr;

    // Decode by comparison against every implemented index, so addresses
    // beyond the bank naturally read as 0 and never hit a register.
    always_comb begin
        rd_data  = '0;
        addr_hit = 1'b0;
        for (int k = 0; k < LOCATIONS; k++) begin
            if (i_address == ADDRESS_SIZE'(k)) begin
                rd_data  = shadow_q[k];
                addr_hit = 1'b1;
            end
        end
    end

    assign wr     = i_write_en & addr_hit;
    assign commit = we_q & ~i_write_en;

    always_comb begin
        for (int k = 0; k < LOCATIONS; k++) begin
            shadow_d[k] = shadow_q[k];
            active_d[k] = active_q[k];
            if (wr && i_address == ADDRESS_SIZE'(k)) begin
                shadow_d[k] = i_data;
            end
            // No write can land on a commit edge (i_write_en is low),
            // so the committed set is exactly the current shadow bank.
            if (commit) begin
                active_d[k] = shadow_q[k];
            end
        end
        data_d   = wr ? i_data : rd_data;
        oe_d     = i_write_en ? '0 : '1;
        update_d = commit;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int k = 0; k < LOCATIONS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            data_q   <= '0;
            oe_q     <= '0;
            update_q <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            for (int k = 0; k < LOCATIONS; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
            data_q   <= data_d;
            oe_q     <= oe_d;
            update_q <= update_d;
            we_q     <= i_write_en;
        end
    end

    always_comb begin
        for (int k = 0; k < LOCATIONS; k++) begin
            o_config[k*DATA_SIZE +: DATA_SIZE] = active_q[k];
        end
    end

    assign o_data    = data_q;
    assign o_data_oe = oe_q;
    assign o_update  = update_q;

endmodule

// File: tb/tb_pwm_config_register_bank.sv
// Testbench for pwm_config_register_bank: vector table, directed
// corner-case sequences and randomized traffic against a bank model.
module tb_pwm_config_register_bank;

    localparam int AW = 6;
    localparam int W  = 8;
    localparam int N  = 49;
    localparam int CW = N * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic [W-1:0]  oe;
    logic [CW-1:0] cfg;
    logic          upd;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: two plain byte arrays plus the previous strobe.
    byte unsigned m_shadow [N];
    byte unsigned m_active [N];
    bit           m_prev_we;
    logic [W-1:0] m_data;
    logic [W-1:0] m_oe;
    logic         m_upd;

    pwm_config_register_bank #(
        .ADDRESS_SIZE(AW),
        .DATA_SIZE   (W),
        .LOCATIONS   (N)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_write_en(we),
        .i_address (addr),
        .i_data    (wdata),
        .o_data    (rdata),
        .o_data_oe (oe),
        .o_config  (cfg),
        .o_update  (upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [CW-1:0] act,
                       input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] model_cfg();
        logic [CW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = m_active[k];
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic w,
                              input int a, input logic [W-1:0] d);
        bit valid;
        if (!r) begin
            for (int k = 0; k < N; k++) begin
                m_shadow[k] = 0;
                m_active[k] = 0;
            end
            m_data = 0; m_oe = 0; m_upd = 0; m_prev_we = 0;
            return;
        end
        valid = (a < N);
        m_upd = m_prev_we && !w;
        if (m_upd) m_active = m_shadow;
        if (w && valid) m_data = d;
        else if (valid) m_data = m_shadow[a];
        else m_data = 0;
        if (w && valid) m_shadow[a] = d;
        m_oe = w ? 8'h00 : 8'hFF;
        m_prev_we = w;
    endtask

    // Apply inputs away from the edge, clock once, check against the model.
    task automatic step(input logic r, input logic w, input int a,
                        input logic [W-1:0] d);
        rst_n = r; we = w; addr = AW'(a); wdata = d;
        @(posedge clk);
        #1;
        model_edge(r, w, a, d);
        chk("m_data", CW'(rdata), CW'(m_data));
        chk("m_oe", CW'(oe), CW'(m_oe));
        chk("m_upd", CW'(upd), CW'(m_upd));
        chk("m_cfg", cfg, model_cfg());
    endtask

    typedef struct {
        logic         rst;
        logic         w;
        int           a;
        logic [W-1:0] d;
        logic [W-1:0] e_data;
        logic [W-1:0] e_oe;
        logic         e_upd;
    } vec_t;

    vec_t vt [8];

    function automatic logic [CW-1:0] pattern_cfg(input logic [W-1:0] r0,
                                                  input logic [W-1:0] r1);
        logic [CW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(k + 16);
        v[0 +: W] = r0;
        v[W +: W] = r1;
        return v;
    endfunction

    initial begin
        logic [CW-1:0] exp_cfg;
        int ups;

        vt[0] = '{1'b0, 1'b1, 0,  8'hAA, 8'h00, 8'h00, 1'b0};
        vt[1] = '{1'b0, 1'b1, 0,  8'hAA, 8'h00, 8'h00, 1'b0};
        vt[2] = '{1'b1, 1'b0, 0,  8'h00, 8'h00, 8'hFF, 1'b0};
        vt[3] = '{1'b1, 1'b1, 5,  8'h5A, 8'h5A, 8'h00, 1'b0};
        vt[4] = '{1'b1, 1'b0, 5,  8'h00, 8'h5A, 8'hFF, 1'b1};
        vt[5] = '{1'b1, 1'b0, 50, 8'h00, 8'h00, 8'hFF, 1'b0};
        vt[6] = '{1'b1, 1'b1, 50, 8'h77, 8'h00, 8'h00, 1'b0};
        vt[7] = '{1'b1, 1'b0, 5,  8'h00, 8'h5A, 8'hFF, 1'b1};

        rst_n = 1'b0; we = 1'b1; addr = '0; wdata = 8'hAA;
        m_prev_we = 0;
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = 0;
            m_active[k] = 0;
        end

        for (int i = 0; i < 8; i++) begin
            step(vt[i].rst, vt[i].w, vt[i].a, vt[i].d);
            chk("vec_data", CW'(rdata), CW'(vt[i].e_data));
            chk("vec_oe", CW'(oe), CW'(vt[i].e_oe));
            chk("vec_upd", CW'(upd), CW'(vt[i].e_upd));
            if (i < 2) chk("vec_rst_cfg", cfg, '0);
        end

        // Full burst: config must hold the old set until the drop edge.
        exp_cfg = '0;
        exp_cfg[5*W +: W] = 8'h5A;
        for (int k = 0; k < N; k++) begin
            step(1'b1, 1'b1, k, W'(k + 16));
            chk("burst_hold", cfg, exp_cfg);
        end
        step(1'b1, 1'b0, 0, 8'h00);
        chk("burst_commit", cfg, pattern_cfg(8'h10, 8'h11));
        chk("burst_upd", CW'(upd), CW'(1'b1));
        chk("burst_oe", CW'(oe), CW'(8'hFF));
        step(1'b1, 1'b0, 0, 8'h00);
        chk("burst_upd_off", CW'(upd), CW'(1'b0));

        // Atomicity of the low two registers.
        step(1'b1, 1'b1, 0, 8'h1F);
        chk("atom_hold0", CW'(cfg[15:0]), CW'(16'h1110));
        step(1'b1, 1'b1, 1, 8'h0F);
        chk("atom_hold1", CW'(cfg[15:0]), CW'(16'h1110));
        step(1'b1, 1'b0, 0, 8'h00);
        chk("atom_commit", CW'(cfg[15:0]), CW'(16'h0F1F));

        // Out-of-range writes are dropped and read back as zero.
        step(1'b1, 1'b1, 49, 8'h55);
        step(1'b1, 1'b1, 63, 8'h77);
        step(1'b1, 1'b0, 49, 8'h00);
        chk("oor_cfg", cfg, pattern_cfg(8'h1F, 8'h0F));
        chk("oor_rd49", CW'(rdata), CW'(8'h00));
        step(1'b1, 1'b0, 63, 8'h00);
        chk("oor_rd63", CW'(rdata), CW'(8'h00));

        // Readback latency and write-first bypass.
        step(1'b1, 1'b1, 12, 8'h0C);
        step(1'b1, 1'b0, 12, 8'h00);
        chk("rd_12", CW'(rdata), CW'(8'h0C));
        step(1'b1, 1'b1, 12, 8'h3C);
        chk("bypass_12", CW'(rdata), CW'(8'h3C));
        step(1'b1, 1'b0, 12, 8'h00);
        chk("rd_12_after", CW'(rdata), CW'(8'h3C));

        // Reset in the middle of a burst: no pulse, everything cleared.
        for (int k = 0; k <= 10; k++) step(1'b1, 1'b1, k, W'(k + 1));
        step(1'b0, 1'b1, 11, 8'h99);
        step(1'b1, 1'b0, 0, 8'h00);
        chk("mid_rst_upd", CW'(upd), CW'(1'b0));
        chk("mid_rst_cfg", cfg, '0);
        chk("mid_rst_rd0", CW'(rdata), CW'(8'h00));
        ups = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0, k, 8'h00);
            chk("mid_rst_shadow", CW'(rdata), CW'(8'h00));
            if (upd) ups++;
        end
        chk("mid_rst_no_pulse", CW'(ups), CW'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 63)),
                 W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
